// File: rtl/unsigned_divide_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Fixed latency of DIVIDEND_W cycles; a zero divisor short-circuits straight to DONE.
module unsigned_divide_seq #(
   parameter int unsigned DIVIDEND_W = 10,
   parameter int unsigned DIVISOR_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dataa,
   input  logic [DIVISOR_W-1:0]  datab,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);

   localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e state_q, state_d;

   logic [DIVIDEND_W-1:0] work_q, work_d;       // dividend shifts out, quotient shifts in
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic [DIVISOR_W-1:0]  prem_q, prem_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  dbz_q, dbz_d;

   // One restoring step on the DIVISOR_W+1-bit shifted partial remainder.
   logic [DIVISOR_W:0]    shifted;
   logic                  ge;
   logic [DIVISOR_W-1:0]  diff;
   logic [DIVISOR_W-1:0]  prem_step;
   logic [DIVIDEND_W-1:0] work_step;

   always_comb begin
      shifted   = {prem_q, work_q[DIVIDEND_W-1]};
      ge        = (shifted >= {1'b0, divisor_q});
      // When ge holds the true difference is below the divisor, so the low bits are exact.
      diff      = shifted[DIVISOR_W-1:0] - divisor_q;
      prem_step = ge ? diff : shifted[DIVISOR_W-1:0];
      work_step = {work_q[DIVIDEND_W-2:0], ge};
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (datab == '0) ? StDone : StCalc;
            end
         end
         StCalc: begin
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == StCalc);
      done = (state_q == StDone);
   end

   // Datapath next-state
   always_comb begin
      work_d      = work_q;
      divisor_d   = divisor_q;
      prem_d      = prem_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               work_d    = dataa;
               divisor_d = datab;
               prem_d    = '0;
               cnt_d     = CntW'(DIVIDEND_W);
               if (datab == '0) begin
                  quotient_d  = '1;
                  remainder_d = dataa[DIVISOR_W-1:0];
                  dbz_d       = 1'b1;
               end
            end
         end
         StCalc: begin
            work_d = work_step;
            prem_d = prem_step;
            cnt_d  = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               quotient_d  = work_step;
               remainder_d = prem_step;
               dbz_d       = 1'b0;
            end
         end
         StDone: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work_q      <= '0;
         divisor_q   <= '0;
         prem_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         work_q      <= work_d;
         divisor_q   <= divisor_d;
         prem_q      <= prem_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/unsigned_divide_seq.md
UNSIGNED_DIVIDE_SEQ -- requirements
Module: unsigned_divide_seq

Interface
REQ-001 Parameter DIVIDEND_W, default 10, SHALL set dividend and quotient width.
REQ-002 Parameter DIVISOR_W, default 5, SHALL set divisor and remainder width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL request a division; it is sampled only in IDLE.
REQ-006 dataa  input  DIVIDEND_W  SHALL be the unsigned dividend, captured when start is accepted.
REQ-007 datab  input  DIVISOR_W  SHALL be the unsigned divisor, captured when start is accepted.
REQ-008 quotient  output  DIVIDEND_W  SHALL be the registered unsigned quotient.
REQ-009 remainder  output  DIVISOR_W  SHALL be the registered unsigned remainder.
REQ-010 busy  output  1  SHALL be high while the divider is in CALC.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking valid quotient and remainder.
REQ-012 div_by_zero  output  1  SHALL flag that the last completed operation had datab == 0.

Function
REQ-013 States SHALL be IDLE, CALC and DONE, encoded in a registered state variable.
REQ-014 In IDLE with start=1, the block SHALL latch dataa and datab and clear the partial remainder.
- Same case: it SHALL load the iteration counter with DIVIDEND_W.
- Same case: it SHALL enter CALC, or enter DONE directly if datab == 0.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-016 Each CALC cycle SHALL perform one restoring-division step on the DIVISOR_W+1-bit partial remainder.
- Shift in the next dividend bit, MSB first.
- Compare against the divisor.
- Subtract if the partial remainder >= divisor.
- Shift the comparison result into the quotient LSB.
REQ-017 CALC SHALL last exactly DIVIDEND_W cycles, then transition to DONE.
REQ-018 The intermediate partial remainder SHALL never exceed DIVISOR_W+1 bits; no result bit SHALL be truncated.
REQ-019 On entry to DONE, quotient, remainder and div_by_zero SHALL update.
- In DONE, done SHALL be 1 for exactly one cycle.
- DONE SHALL then return to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: with start accepted at edge E, done SHALL be high in the cycle after edge E+DIVIDEND_W (E+10 by default).
REQ-021 With datab == 0, DONE SHALL be entered at edge E and done SHALL be high in the cycle after E.
- quotient SHALL be all ones (1023).
- remainder SHALL be dataa[DIVISOR_W-1:0].
- div_by_zero SHALL be 1.
REQ-022 With datab != 0, div_by_zero SHALL be 0 at completion.
REQ-023 A start asserted in CALC or DONE SHALL be ignored; it is not queued.
REQ-024 dataa and datab changes after acceptance SHALL NOT affect the operation in progress.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last values from one DONE until the next DONE.
REQ-026 For every non-zero divisor, the result SHALL satisfy quotient*datab + remainder == dataa and remainder < datab.

Reset
REQ-027 On reset, the following SHALL occur on the same rising edge:
- state = IDLE;
- busy = 0, done = 0, div_by_zero = 0;
- quotient = 0, remainder = 0;
- counter and internal registers = 0.
REQ-028 Reset SHALL take priority over start and SHALL abort a CALC in progress with no done pulse.
REQ-029 The first start accepted after reset is released SHALL behave per REQ-014.

Verification
REQ-030 dataa=1000, datab=31, start pulse -> busy for 10 cycles, then done=1 with quotient=32, remainder=8, div_by_zero=0.
REQ-031 dataa=5, datab=7 -> quotient=0, remainder=5; dataa=1023, datab=1 -> quotient=1023, remainder=0.
REQ-032 dataa=100, datab=0 -> done in the cycle after start, with quotient=1023, remainder=4, div_by_zero=1.
REQ-033 start re-asserted with new operands mid-CALC -> ignored; the original result completes at the original latency.
REQ-034 reset asserted 4 cycles into CALC -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
REQ-035 100 random operand pairs (random draws over the full width of dataa and datab; zero divisors allowed) -> each result matches behavioural / and %, or REQ-021 when datab=0.
- The bench SHALL count mismatches and report pass only when the count is 0.
